adder_serial: RTL and testbench
===============================

# adder_serial

Parametrised digit-serial adder with valid/ready handshakes. It is the multi-cycle successor to the team's combinational 4-bit ripple adder. Each accepted operand pair is summed DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for a narrow carry chain. It sits between operand-producing and result-consuming blocks that use valid/ready flow control.

## Interface
Parameters:
- WIDTH, default 16: operand/result width in bits. Must be ≥1.
- DIGIT, default 4: bits processed per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails with a fatal error. NDIG = WIDTH/DIGIT.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in.
- sub, input, 1: subtract mode. Present only with ADDER_SUB_EN.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- sum, output, WIDTH: result.
- cout, output, 1: carry-out of the MSB.
- ovf, output, 1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture a, b, cin (and sub) into registers, clear the digit counter, and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, add the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the DIGIT-bit result into the MSB end of the sum register.
  - Update the carry register and increment the counter.
  - After NDIG cycles, go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - Hold until out_ready=1, then go to IDLE.
  - in_ready=0 throughout DONE.
- Arithmetic: {cout,sum} = a + b + cin, computed at full WIDTH+1 precision.
- ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), where b_eff is the B operand actually added.
- Inputs a, b, cin and sub are ignored outside the IDLE accept cycle. Changing them during RUN has no effect.
- NDIG=1 (DIGIT=WIDTH) is legal: RUN lasts exactly one cycle.

## Timing
- Reset: when rst_n is low at a rising edge, the block goes to IDLE with out_valid=0 and sum, cout, ovf, counter and carry all 0. in_ready=1 from that edge.
- Reset mid-operation, in RUN or DONE: the operation is aborted and the result discarded. No out_valid pulse follows.
- Accept: handshake on the edge where in_valid && in_ready.
- Latency:
  - Accept at edge E0 → out_valid=1 in the cycle following edge E0+NDIG.
  - With out_ready held at 1, in_ready is high again after edge E0+NDIG+1.
  - Minimum initiation interval is NDIG+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, sum, cout and ovf hold unchanged indefinitely.
- Outputs are registered only. No combinational path exists from inputs to outputs, except in_ready and out_valid, which decode the state.
- in_valid asserted outside IDLE is ignored and not queued. The producer holds it until in_ready.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists.
  - sub=1 at accept computes a − b: b_eff = ~b, carry-in forced to 1, cin ignored.
  - cout=1 means no borrow. ovf uses b_eff.
  - sub=0 behaves as addition.
- ADDER_SUB_EN undefined: there is no sub port; b_eff = b and carry-in = cin.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Basic add: a=0x0003, b=0x0003, cin=0 → sum=0x0006, cout=0, ovf=0. out_valid rises 4 cycles after accept.
- Full carry: a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0. Also a=0x000B, b=0x0007, cin=1 → sum=0x0013, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid and sum stay stable and in_ready stays 0. Release → one transfer, then in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 two cycles after accept → next cycle out_valid=0, sum=0, in_ready=1. No result ever appears.
- ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/adder_serial.sv
// Digit-serial adder: sums WIDTH-bit operands DIGIT bits per clock with valid/ready handshakes.
// Optional subtract mode is compiled in when ADDER_SUB_EN is defined.
module adder_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned DigSafe = (DIGIT == 0) ? 1 : DIGIT;
    localparam int unsigned NDIG    = WIDTH / DigSafe;
    localparam int unsigned CW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam bit          BadCfg  = (WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DigSafe) != 0);

    generate
        if (BadCfg) begin : g_bad_cfg
            $fatal(1, "adder_serial: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]       a_q, b_q, sum_q;
    logic                   cy_q, cout_q, ovf_q;
    logic                   a_msb_q, b_msb_q;
    logic [CW-1:0]          cnt_q;
    logic                   last_digit;
    logic                   accept;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       b_eff;
    logic                   c_eff;

`ifdef ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign last_digit = (cnt_q == CW'(NDIG - 1));
    assign accept     = (state_q == StIdle) && in_valid;
    assign dsum       = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
    // New digit enters at the MSB end; low digits fall off as the register shifts right.
    assign sum_cat    = {dsum[DIGIT-1:0], sum_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                if (last_digit) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            cy_q    <= c_eff;
            cnt_q   <= '0;
            // Operand sign bits are shifted out during RUN, so keep them for the overflow test.
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
        end else if (state_q == StRun) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            cy_q  <= dsum[DIGIT];
            sum_q <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            cnt_q <= cnt_q + CW'(1);
            if (last_digit) begin
                cout_q <= dsum[DIGIT];
                ovf_q  <= (a_msb_q == b_msb_q) && (dsum[DIGIT-1] != a_msb_q);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_serial.sv
// Self-checking bench for adder_serial (WIDTH=16, DIGIT=4) against an arithmetic reference model.
// Subtract scenarios are exercised when ADDER_SUB_EN is defined.
module tb_adder_serial;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;
`ifdef ADDER_SUB_EN
    localparam bit HasSub = 1'b1;
`else
    localparam bit HasSub = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub_drv;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    adder_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        logic [W-1:0] ye;
        logic         ce;
        logic [W:0]   r;
        logic         o;
        ye = s ? ~y : y;
        ce = s ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
        o  = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
        return {o, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction with out_ready held high; inputs are scrambled after accept.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc,
                         input logic ts, output logic [W+1:0] res, output int lat);
        a = ta; b = tb_op; cin = tc; sub_drv = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        sub_drv = HasSub ? 1'($urandom) : 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        res = {ovf, cout, sum};
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub_drv = 1'b0;
        tick(); tick();
        total++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, expected 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4]  = '{16'h0003, 16'hFFFF, 16'h000B, 16'h7FFF};
        logic [W-1:0] tbv[4] = '{16'h0003, 16'hFFFF, 16'h0007, 16'h0001};
        logic         tc[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W+1:0] ex[4]  = '{{2'b00, 16'h0006}, {2'b01, 16'hFFFF},
                                 {2'b00, 16'h0013}, {2'b10, 16'h8000}};
        logic [W+1:0] res;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (in_ready !== 1'b1) $display("FAIL dir_ready[%0d]: got %b expected 1", i, in_ready);
            else passed++;
            do_op(ta[i], tbv[i], tc[i], 1'b0, res, lat);
            total++;
            if (res !== ex[i]) $display("FAIL dir_result[%0d]: got %h expected %h", i, res, ex[i]);
            else passed++;
            total++;
            if (lat != NDIG) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, NDIG);
            else passed++;
        end
    endtask

    task automatic test_sub();
        logic [W+1:0] res;
        int           lat;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, res, lat);
        total++;
        if (res !== {2'b00, 16'hFFFE}) $display("FAIL sub_5_7: got %h expected %h", res, {2'b00, 16'hFFFE});
        else passed++;
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, res, lat);
        total++;
        if (res !== {2'b11, 16'h7FFF}) $display("FAIL sub_8000_1: got %h expected %h", res, {2'b11, 16'h7FFF});
        else passed++;
    endtask

    task automatic test_random();
        logic [W+1:0] res, ex;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            rs = HasSub ? 1'($urandom) : 1'b0;
            if (i % 8 == 0) rb = ~ra;
            ex = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, res, lat);
            total++;
            if (res !== ex || lat != NDIG)
                $display("FAIL rand[%0d] a=%h b=%h c=%b s=%b: got %h lat=%0d expected %h lat=%0d",
                         i, ra, rb, rc, rs, res, lat, ex, NDIG);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] ex;
        int           n;
        ex = model(16'h1234, 16'h4321, 1'b1, 1'b0);
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h4321; cin = 1'b1; sub_drv = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom);
            in_valid = 1'($urandom);
            tick();
            total++;
            if ({out_valid, in_ready, ovf, cout, sum} !== {2'b10, ex})
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=%h",
                         i, out_valid, in_ready, {ovf, cout, sum}, ex);
            else passed++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if ({out_valid, in_ready, sum, cout, ovf} !== {2'b01, 16'h0, 2'b00})
            $display("FAIL rst_mid: got vld=%b rdy=%b sum=%h cout=%b ovf=%b expected 0 1 0000 0 0",
                     out_valid, in_ready, sum, cout, ovf);
        else passed++;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL rst_no_result: got %0d valid cycles expected 0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] q[$];
        logic [W+1:0] ex;
        int           prev, n_acc, n_out;
        prev = -1; n_acc = 0; n_out = 0;
        out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        sub_drv = HasSub ? 1'($urandom) : 1'b0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && (n_acc < 8 || q.size() != 0); cyc++) begin
            if (out_valid) begin
                n_out++;
                total++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_extra: got unexpected result %h expected none", {ovf, cout, sum});
                end else begin
                    ex = q.pop_front();
                    if ({ovf, cout, sum} !== ex)
                        $display("FAIL b2b_result[%0d]: got %h expected %h", n_out, {ovf, cout, sum}, ex);
                    else passed++;
                end
            end
            if (in_ready && n_acc < 8) begin
                q.push_back(model(a, b, cin, sub_drv));
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev != NDIG + 2)
                        $display("FAIL b2b_interval: got %0d expected %0d", cyc - prev, NDIG + 2);
                    else passed++;
                end
                prev = cyc;
                n_acc++;
            end else begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                sub_drv = HasSub ? 1'($urandom) : 1'b0;
                if (n_acc >= 8) in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (n_out != 8 || q.size() != 0)
            $display("FAIL b2b_count: got %0d results expected 8", n_out);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        if (HasSub) test_sub();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
